// File: rtl/mem_loop_ctrl_if.sv
// Handshake/config bundle between the loop sequencer and its host/datapath.
// abort exists only when LOOP_CTRL_ABORT_EN is defined.
interface mem_loop_ctrl_if #(
  parameter int SLOT_BW = 6,
  parameter int DIM_BW  = 6,
  parameter int HOP_BW  = 2
);
  logic               start;
  logic [SLOT_BW-1:0] num_slots;
  logic [DIM_BW-1:0]  num_dims;
  logic [HOP_BW-1:0]  num_hops;
  logic               stall;
  logic               norm_done;
`ifdef LOOP_CTRL_ABORT_EN
  logic               abort;
`endif
  logic               busy;
  logic               valid;
  logic [1:0]         phase;
  logic [HOP_BW-1:0]  hop_idx;
  logic [SLOT_BW-1:0] slot_idx;
  logic [DIM_BW-1:0]  dim_idx;
  logic               first_dim;
  logic               last_dim;
  logic               norm_start;
  logic               done;

`ifdef LOOP_CTRL_ABORT_EN
  modport master (
    output start, num_slots, num_dims, num_hops, stall, norm_done, abort,
    input  busy, valid, phase, hop_idx, slot_idx, dim_idx,
           first_dim, last_dim, norm_start, done
  );
  modport slave (
    input  start, num_slots, num_dims, num_hops, stall, norm_done, abort,
    output busy, valid, phase, hop_idx, slot_idx, dim_idx,
           first_dim, last_dim, norm_start, done
  );
`else
  modport master (
    output start, num_slots, num_dims, num_hops, stall, norm_done,
    input  busy, valid, phase, hop_idx, slot_idx, dim_idx,
           first_dim, last_dim, norm_start, done
  );
  modport slave (
    input  start, num_slots, num_dims, num_hops, stall, norm_done,
    output busy, valid, phase, hop_idx, slot_idx, dim_idx,
           first_dim, last_dim, norm_start, done
  );
`endif
endinterface

// File: rtl/mem_loop_ctrl.sv
// MemN2N loop sequencer: hop/slot/dim counters with score, norm-wait and read phases.
// Optional early termination input enabled by defining LOOP_CTRL_ABORT_EN.
module mem_loop_ctrl #(
  parameter int SLOT_BW = 6,
  parameter int DIM_BW  = 6,
  parameter int HOP_BW  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_loop_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCORE,
    S_WAIT_NORM,
    S_READ,
    S_FINISH
  } state_t;

  state_t             state_q;
  logic [SLOT_BW-1:0] cfg_slots_q;
  logic [DIM_BW-1:0]  cfg_dims_q;
  logic [HOP_BW-1:0]  cfg_hops_q;
  logic [HOP_BW-1:0]  hop_q;
  logic [SLOT_BW-1:0] slot_q;
  logic [DIM_BW-1:0]  dim_q;
  logic               valid_q;
  logic               busy_q;
  logic [1:0]         phase_q;
  logic               norm_start_q;
  logic               done_q;

  logic beat_acc;
  logic dim_wrap;
  logic slot_wrap;
  logic hop_last;
  logic abort_req;

  assign beat_acc  = valid_q && !bus.stall;
  assign dim_wrap  = (dim_q == cfg_dims_q);
  assign slot_wrap = (slot_q == cfg_slots_q);
  assign hop_last  = (hop_q == cfg_hops_q);

`ifdef LOOP_CTRL_ABORT_EN
  assign abort_req = bus.abort && (state_q != S_IDLE);
`else
  assign abort_req = 1'b0;
`endif

  // Configuration is pure data: captured on an accepted start, never reset.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && bus.start) begin
      cfg_slots_q <= bus.num_slots;
      cfg_dims_q  <= bus.num_dims;
      cfg_hops_q  <= bus.num_hops;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      hop_q        <= '0;
      slot_q       <= '0;
      dim_q        <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      phase_q      <= 2'd0;
      norm_start_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      norm_start_q <= 1'b0;
      done_q       <= 1'b0;
      if (abort_req) begin
        state_q <= S_IDLE;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
        phase_q <= 2'd0;
        done_q  <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.start) begin
              state_q <= S_SCORE;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
              phase_q <= 2'd1;
              hop_q   <= '0;
              slot_q  <= '0;
              dim_q   <= '0;
            end
          end
          S_SCORE, S_READ: begin
            if (beat_acc) begin
              if (!dim_wrap) begin
                dim_q <= dim_q + DIM_BW'(1);
              end else if (!slot_wrap) begin
                dim_q  <= '0;
                slot_q <= slot_q + SLOT_BW'(1);
              end else if (state_q == S_SCORE) begin
                dim_q        <= '0;
                slot_q       <= '0;
                state_q      <= S_WAIT_NORM;
                valid_q      <= 1'b0;
                phase_q      <= 2'd2;
                norm_start_q <= 1'b1;
              end else if (hop_last) begin
                // Indices keep the last beat's values until the next start.
                state_q <= S_FINISH;
                valid_q <= 1'b0;
                phase_q <= 2'd0;
                done_q  <= 1'b1;
              end else begin
                dim_q   <= '0;
                slot_q  <= '0;
                hop_q   <= hop_q + HOP_BW'(1);
                state_q <= S_SCORE;
                phase_q <= 2'd1;
              end
            end
          end
          S_WAIT_NORM: begin
            if (bus.norm_done) begin
              state_q <= S_READ;
              valid_q <= 1'b1;
              phase_q <= 2'd3;
            end
          end
          S_FINISH: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            phase_q <= 2'd0;
          end
        endcase
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.valid      = valid_q;
  assign bus.phase      = phase_q;
  assign bus.hop_idx    = hop_q;
  assign bus.slot_idx   = slot_q;
  assign bus.dim_idx    = dim_q;
  assign bus.norm_start = norm_start_q;
  assign bus.done       = done_q;
  assign bus.first_dim  = valid_q && (dim_q == '0);
  assign bus.last_dim   = valid_q && dim_q_is_last();

  function automatic logic dim_q_is_last();
    return dim_q == cfg_dims_q;
  endfunction

endmodule

// File: tb/tb_mem_loop_ctrl.sv
// Directed bench for mem_loop_ctrl: run sequencing, stall, multi-hop, spurious inputs, reset, abort.
module tb_mem_loop_ctrl;
  localparam int SLOT_BW = 6;
  localparam int DIM_BW  = 6;
  localparam int HOP_BW  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;

  mem_loop_ctrl_if #(.SLOT_BW(SLOT_BW), .DIM_BW(DIM_BW), .HOP_BW(HOP_BW)) bus ();

  mem_loop_ctrl #(.SLOT_BW(SLOT_BW), .DIM_BW(DIM_BW), .HOP_BW(HOP_BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int ns, input int nd, input int nh);
    bus.num_slots = SLOT_BW'(ns);
    bus.num_dims  = DIM_BW'(nd);
    bus.num_hops  = HOP_BW'(nh);
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
    // Scramble the config: the run must only use the latched copy.
    bus.num_slots = SLOT_BW'(ns + 5);
    bus.num_dims  = DIM_BW'(nd + 3);
    bus.num_hops  = HOP_BW'(nh + 1);
    chk("start_busy", 32'(bus.busy), 32'd1);
  endtask

  // Checks every beat of one phase with no stall; optional spurious start/norm_done at beat (0,1).
  task automatic run_phase(input int ns, input int nd, input int hop, input int ph, input bit spur);
    for (int s = 0; s <= ns; s++) begin
      for (int d = 0; d <= nd; d++) begin
        if (spur && s == 0 && d == 1) begin
          bus.start     = 1'b1;
          bus.norm_done = 1'b1;
        end
        chk("beat_valid", 32'(bus.valid), 32'd1);
        chk("beat_phase", 32'(bus.phase), 32'(ph));
        chk("beat_hop",   32'(bus.hop_idx), 32'(hop));
        chk("beat_slot",  32'(bus.slot_idx), 32'(s));
        chk("beat_dim",   32'(bus.dim_idx), 32'(d));
        chk("beat_first", 32'(bus.first_dim), 32'(d == 0));
        chk("beat_last",  32'(bus.last_dim), 32'(d == nd));
        tick();
        bus.start     = 1'b0;
        bus.norm_done = 1'b0;
      end
    end
  endtask

  task automatic norm_wait(input int extra);
    chk("norm_phase", 32'(bus.phase), 32'd2);
    chk("norm_pulse", 32'(bus.norm_start), 32'd1);
    chk("norm_valid", 32'(bus.valid), 32'd0);
    for (int i = 0; i < extra; i++) begin
      tick();
      chk("norm_hold_phase", 32'(bus.phase), 32'd2);
      chk("norm_pulse_off", 32'(bus.norm_start), 32'd0);
    end
    bus.norm_done = 1'b1;
    tick();
    bus.norm_done = 1'b0;
  endtask

  task automatic finish_chk();
    chk("fin_done", 32'(bus.done), 32'd1);
    chk("fin_busy", 32'(bus.busy), 32'd1);
    chk("fin_valid", 32'(bus.valid), 32'd0);
    tick();
    chk("idle_done", 32'(bus.done), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_phase", 32'(bus.phase), 32'd0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.num_slots = '0;
    bus.num_dims  = '0;
    bus.num_hops  = '0;
    bus.stall     = 1'b0;
    bus.norm_done = 1'b0;
`ifdef LOOP_CTRL_ABORT_EN
    bus.abort     = 1'b0;
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_phase", 32'(bus.phase), 32'd0);
    chk("rst_done",  32'(bus.done), 32'd0);
    chk("rst_nstart", 32'(bus.norm_start), 32'd0);
    chk("rst_idx", 32'({bus.hop_idx, bus.slot_idx, bus.dim_idx}), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic run: 3 slots x 4 dims, single hop, softmax takes 5 cycles.
    start_run(2, 3, 0);
    run_phase(2, 3, 0, 1, 1'b0);
    norm_wait(5);
    run_phase(2, 3, 0, 3, 1'b0);
    finish_chk();

    // Back-to-back start in the cycle right after done.
    start_run(0, 0, 0);
    run_phase(0, 0, 0, 1, 1'b0);
    norm_wait(0);
    run_phase(0, 0, 0, 3, 1'b0);
    finish_chk();

    // Stall every other cycle during SCORE.
    start_run(1, 1, 0);
    for (int b = 0; b < 4; b++) begin
      bus.stall = 1'b1;
      chk("stall_slot_pre", 32'(bus.slot_idx), 32'(b / 2));
      chk("stall_dim_pre",  32'(bus.dim_idx), 32'(b % 2));
      tick();
      chk("stall_slot_hold", 32'(bus.slot_idx), 32'(b / 2));
      chk("stall_dim_hold",  32'(bus.dim_idx), 32'(b % 2));
      chk("stall_phase", 32'(bus.phase), 32'd1);
      bus.stall = 1'b0;
      tick();
    end
    norm_wait(1);
    run_phase(1, 1, 0, 3, 1'b0);
    finish_chk();

    // Three hops of single-beat phases; norm_done coincides with norm_start.
    start_run(0, 0, 2);
    for (int h = 0; h < 3; h++) begin
      run_phase(0, 0, h, 1, 1'b0);
      norm_wait(0);
      run_phase(0, 0, h, 3, 1'b0);
    end
    finish_chk();

    // Spurious start/norm_done while beats are live.
    start_run(1, 1, 0);
    run_phase(1, 1, 0, 1, 1'b1);
    norm_wait(2);
    run_phase(1, 1, 0, 3, 1'b1);
    finish_chk();

    // Asynchronous reset in the middle of READ.
    start_run(1, 1, 1);
    run_phase(1, 1, 0, 1, 1'b0);
    norm_wait(0);
    chk("midread_phase", 32'(bus.phase), 32'd3);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_busy",  32'(bus.busy), 32'd0);
    chk("arst_valid", 32'(bus.valid), 32'd0);
    chk("arst_phase", 32'(bus.phase), 32'd0);
    chk("arst_idx", 32'({bus.hop_idx, bus.slot_idx, bus.dim_idx}), 32'd0);
    tick();
    chk("arst_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_done", 32'(bus.done), 32'd0);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    start_run(0, 1, 0);
    run_phase(0, 1, 0, 1, 1'b0);
    norm_wait(1);
    run_phase(0, 1, 0, 3, 1'b0);
    finish_chk();

`ifdef LOOP_CTRL_ABORT_EN
    // Abort while waiting for the softmax unit.
    start_run(1, 0, 1);
    run_phase(1, 0, 0, 1, 1'b0);
    chk("abort_in_norm", 32'(bus.phase), 32'd2);
    bus.abort     = 1'b1;
    bus.norm_done = 1'b1;
    tick();
    bus.abort     = 1'b0;
    bus.norm_done = 1'b0;
    chk("abort_busy",  32'(bus.busy), 32'd0);
    chk("abort_valid", 32'(bus.valid), 32'd0);
    chk("abort_phase", 32'(bus.phase), 32'd0);
    chk("abort_done",  32'(bus.done), 32'd1);
    tick();
    chk("abort_done_off", 32'(bus.done), 32'd0);
    chk("abort_idle_busy", 32'(bus.busy), 32'd0);
    start_run(1, 0, 0);
    run_phase(1, 0, 0, 1, 1'b0);
    norm_wait(0);
    run_phase(1, 0, 0, 3, 1'b0);
    finish_chk();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
